// File: rtl/sram_array_ctrl_if.sv
// Request/response and macro-side signals of the SRAM sequencer.
// master = core and macro side, slave = sram_array_ctrl.
interface sram_array_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              sram_write_en;
  logic              sram_sense_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  sram_write_en, sram_sense_en, sram_addr, sram_din
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output sram_write_en, sram_sense_en, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_array_ctrl.sv
// Strobe sequencer in front of the 4K x 8 compiled SRAM macro.
// Define SRAM_CTRL_READBACK_EN to verify every write by reading it back.
module sram_array_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int WRITE_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  sram_array_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_REC,
    RD_SETUP,
    RD_SENSE,
    RD_CAP
`ifdef SRAM_CTRL_READBACK_EN
    ,
    RB_SENSE,
    RB_CAP
`endif
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WRITE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              sense_q, sense_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef SRAM_CTRL_READBACK_EN
  logic              err_q, err_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      sense_q     <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef SRAM_CTRL_READBACK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      sense_q     <= sense_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
`ifdef SRAM_CTRL_READBACK_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
`ifdef SRAM_CTRL_READBACK_EN
    err_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          if (bus.req_we) begin
            din_d   = bus.req_wdata;
            cnt_d   = CNT_INIT;
            state_d = WR;
          end else begin
            state_d = RD_SETUP;
          end
        end
      end
      WR: begin
        if (cnt_q == 4'd0) state_d = WR_REC;
        else cnt_d = cnt_q - 4'd1;
      end
      WR_REC: begin
`ifdef SRAM_CTRL_READBACK_EN
        state_d = RB_SENSE;
`else
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
`endif
      end
      RD_SETUP: state_d = RD_SENSE;
      RD_SENSE: state_d = RD_CAP;
      RD_CAP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rdata_d     = bus.sram_dout;
      end
`ifdef SRAM_CTRL_READBACK_EN
      RB_SENSE: state_d = RB_CAP;
      RB_CAP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        err_d       = (bus.sram_dout != din_q);
      end
`endif
      default: state_d = IDLE;
    endcase
    // strobes are registered from the next state so they align with it
    we_d    = (state_d == WR);
    sense_d = 1'b1;
    if (state_d == RD_SENSE) sense_d = 1'b0;
`ifdef SRAM_CTRL_READBACK_EN
    if (state_d == RB_SENSE) sense_d = 1'b0;
`endif
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.sram_write_en = we_q;
  assign bus.sram_sense_en = sense_q;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_din      = din_q;
`ifdef SRAM_CTRL_READBACK_EN
  assign bus.rsp_err       = err_q;
`else
  assign bus.rsp_err       = 1'b0;
`endif
endmodule

// File: tb/tb_sram_array_ctrl.sv
// Self-checking bench for sram_array_ctrl with a behavioural macro model.
// Random ops are checked against a reference memory and latency rules.
module tb_sram_array_ctrl;
  localparam int WC = 2;
`ifdef SRAM_CTRL_READBACK_EN
  localparam int WLAT = WC + 4;
`else
  localparam int WLAT = WC + 2;
`endif
  localparam int RLAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  sram_array_ctrl_if #(.ADDR_W(12), .DATA_W(8)) ifc ();

  sram_array_ctrl #(
    .ADDR_W(12), .DATA_W(8), .WRITE_CYCLES(WC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  // macro stand-in: writes while write_en high, senses while sense_en low
  logic [7:0] macro_mem [4096];
  logic [7:0] dout_q = 8'h00;
  logic       force0 = 1'b0;
  always @(posedge clk) begin
    if (ifc.sram_write_en) macro_mem[ifc.sram_addr] <= ifc.sram_din;
    if (!ifc.sram_sense_en) dout_q <= macro_mem[ifc.sram_addr];
  end
  assign ifc.sram_dout = force0 ? 8'h00 : dout_q;

  logic [7:0] ref_mem [int unsigned];
  logic [7:0] last_din = 8'h00;
  logic [7:0] last_rd = 8'h00;

  task automatic run_op(input logic we, input logic [11:0] a,
                        input logic [7:0] d, output int lat,
                        output int we_n, output int se_n,
                        output int se_at, output int bad_n,
                        output logic [7:0] rd, output logic er);
    int k;
    logic [7:0] din_exp;
    din_exp = we ? d : last_din;
    lat = 0; we_n = 0; se_n = 0; se_at = 0; bad_n = 0;
    rd = 8'hxx; er = 1'bx;
    k = 0;
    while (!ifc.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    ifc.req_valid = 1'b1;
    ifc.req_we = we;
    ifc.req_addr = a;
    ifc.req_wdata = d;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    ifc.req_we = 1'($urandom);
    ifc.req_addr = 12'($urandom);
    ifc.req_wdata = 8'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (ifc.sram_write_en) we_n++;
      if (!ifc.sram_sense_en) begin
        se_n++;
        if (se_at == 0) se_at = c;
      end
      if (ifc.sram_write_en && !ifc.sram_sense_en) bad_n++;
      if (ifc.sram_addr !== a || ifc.sram_din !== din_exp) bad_n++;
      if (ifc.req_ready && !ifc.rsp_valid) bad_n++;
      if (ifc.rsp_valid) begin
        lat = c;
        rd = ifc.rsp_rdata;
        er = ifc.rsp_err;
        break;
      end
      @(negedge clk);
    end
    if (we) last_din = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_din = 8'h00;
    last_rd = 8'h00;
    #1;
    total++;
    if (ifc.sram_sense_en !== 1'b1) begin
      bad++; $display("FAIL reset_sense got=%b want=1", ifc.sram_sense_en);
    end
    total++;
    if (ifc.sram_write_en !== 1'b0) begin
      bad++; $display("FAIL reset_we got=%b want=0", ifc.sram_write_en);
    end
    total++;
    if (ifc.req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", ifc.req_ready);
    end
    total++;
    if (ifc.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got=%b want=0", ifc.rsp_valid);
    end
    total++;
    if ({ifc.sram_addr, ifc.sram_din, ifc.rsp_rdata, ifc.rsp_err} !== 29'd0) begin
      bad++; $display("FAIL reset_regs addr=%h din=%h rd=%h err=%b want 0",
        ifc.sram_addr, ifc.sram_din, ifc.rsp_rdata, ifc.rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    int lat, wn, sn, sa, bn;
    logic [7:0] rd;
    logic er;
    run_op(1'b1, 12'h0A5, 8'h3C, lat, wn, sn, sa, bn, rd, er);
    ref_mem[12'h0A5] = 8'h3C;
    total++;
    if (lat != WLAT) begin
      bad++; $display("FAIL wr_latency got=%0d want=%0d", lat, WLAT);
    end
    total++;
    if (wn != WC) begin
      bad++; $display("FAIL wr_we_cycles got=%0d want=%0d", wn, WC);
    end
    total++;
    if (bn != 0) begin
      bad++; $display("FAIL wr_strobe_bus got=%0d want=0", bn);
    end
    total++;
    if (rd !== last_rd || er !== 1'b0) begin
      bad++; $display("FAIL wr_rsp rd=%h err=%b want rd=%h err=0", rd, er, last_rd);
    end
  endtask

  task automatic test_read();
    int lat, wn, sn, sa, bn;
    logic [7:0] rd;
    logic er;
    run_op(1'b0, 12'h0A5, 8'hEE, lat, wn, sn, sa, bn, rd, er);
    last_rd = 8'h3C;
    total++;
    if (lat != RLAT) begin
      bad++; $display("FAIL rd_latency got=%0d want=%0d", lat, RLAT);
    end
    total++;
    if (sn != 1 || sa != 2) begin
      bad++; $display("FAIL rd_sense cycles=%0d at=%0d want 1 at 2", sn, sa);
    end
    total++;
    if (wn != 0 || bn != 0) begin
      bad++; $display("FAIL rd_strobes we=%0d bus=%0d want 0 0", wn, bn);
    end
    total++;
    if (rd !== 8'h3C || er !== 1'b0) begin
      bad++; $display("FAIL rd_data got=%h err=%b want=3c err=0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2, stray;
    lat = 0; lat2 = 0; stray = 0;
    ifc.req_valid = 1'b1;
    ifc.req_we = 1'b1;
    ifc.req_addr = 12'hFFF;
    ifc.req_wdata = 8'hA5;
    @(negedge clk);
    ifc.req_we = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ifc.rsp_valid) begin
        lat = c;
        break;
      end
      if (ifc.req_ready) stray++;
      @(negedge clk);
    end
    total++;
    if (lat != WLAT || stray != 0) begin
      bad++; $display("FAIL b2b_wr lat=%0d stray=%0d want %0d 0", lat, stray, WLAT);
    end
    total++;
    if (ifc.req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready_at_rsp got=%b want=1", ifc.req_ready);
    end
    @(negedge clk);
    ifc.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ifc.rsp_valid) begin
        lat2 = c;
        break;
      end
      @(negedge clk);
    end
    ref_mem[12'hFFF] = 8'hA5;
    last_din = 8'hA5;
    last_rd = 8'hA5;
    total++;
    if (lat2 != RLAT) begin
      bad++; $display("FAIL b2b_rd_latency got=%0d want=%0d", lat2, RLAT);
    end
    total++;
    if (ifc.rsp_rdata !== 8'hA5 || ifc.sram_addr !== 12'hFFF) begin
      bad++; $display("FAIL b2b_rd_data got=%h addr=%h want=a5 fff",
        ifc.rsp_rdata, ifc.sram_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, wn, sn, sa, bn;
    logic [7:0] rd;
    logic er;
    logic we;
    logic [11:0] a;
    logic [7:0] d;
    logic [11:0] pool [6];
    pool = '{12'h000, 12'hFFF, 12'h0A5, 12'h800, 12'h7FF, 12'h013};
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      a = pool[$urandom_range(0, 5)];
      d = 8'($urandom);
      run_op(we, a, d, lat, wn, sn, sa, bn, rd, er);
      total++;
      if (lat != (we ? WLAT : RLAT) || bn != 0 || wn != (we ? WC : 0)) begin
        bad++; $display("FAIL rnd_timing op=%0d we=%b lat=%0d we_n=%0d bus=%0d",
          i, we, lat, wn, bn);
      end
      total++;
      if (er !== 1'b0) begin
        bad++; $display("FAIL rnd_err op=%0d got=%b want=0", i, er);
      end
      if (we) begin
        ref_mem[a] = d;
        total++;
        if (rd !== last_rd) begin
          bad++; $display("FAIL rnd_wr_rdata op=%0d got=%h want=%h", i, rd, last_rd);
        end
      end else if (ref_mem.exists(a)) begin
        total++;
        if (rd !== ref_mem[a] || sn != 1 || sa != 2) begin
          bad++; $display("FAIL rnd_rd op=%0d addr=%h got=%h want=%h sense=%0d@%0d",
            i, a, rd, ref_mem[a], sn, sa);
        end
        last_rd = ref_mem[a];
      end else begin
        last_rd = rd;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int stray;
    stray = 0;
    ifc.req_valid = 1'b1;
    ifc.req_we = 1'b1;
    ifc.req_addr = 12'h123;
    ifc.req_wdata = 8'h77;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (ifc.sram_write_en !== 1'b1) begin
      bad++; $display("FAIL mid_we_before got=%b want=1", ifc.sram_write_en);
    end
    reset = 1'b1;
    #1;
    total++;
    if (ifc.sram_write_en !== 1'b0 || ifc.sram_sense_en !== 1'b1) begin
      bad++; $display("FAIL mid_async we=%b sense=%b want 0 1",
        ifc.sram_write_en, ifc.sram_sense_en);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[12'h123] = 8'h77;
    last_din = 8'h00;
    last_rd = 8'h00;
    #1;
    total++;
    if (ifc.req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready got=%b want=1", ifc.req_ready);
    end
    for (int c = 0; c < 8; c++) begin
      if (ifc.rsp_valid) stray++;
      @(negedge clk);
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL mid_no_rsp got=%0d want=0", stray);
    end
  endtask

`ifdef SRAM_CTRL_READBACK_EN
  task automatic test_readback();
    int lat, wn, sn, sa, bn;
    logic [7:0] rd;
    logic er;
    force0 = 1'b1;
    run_op(1'b1, 12'h0F0, 8'h55, lat, wn, sn, sa, bn, rd, er);
    force0 = 1'b0;
    ref_mem[12'h0F0] = 8'h55;
    total++;
    if (lat != WC + 4 || er !== 1'b1) begin
      bad++; $display("FAIL rb_forced lat=%0d err=%b want %0d 1", lat, er, WC + 4);
    end
    total++;
    if (rd !== last_rd) begin
      bad++; $display("FAIL rb_rdata got=%h want=%h", rd, last_rd);
    end
    @(negedge clk);
    run_op(1'b1, 12'h0F1, 8'h66, lat, wn, sn, sa, bn, rd, er);
    ref_mem[12'h0F1] = 8'h66;
    total++;
    if (lat != WC + 4 || er !== 1'b0 || sn != 1) begin
      bad++; $display("FAIL rb_clean lat=%0d err=%b sense=%0d want %0d 0 1",
        lat, er, sn, WC + 4);
    end
  endtask
`endif

  initial begin
    ifc.req_valid = 1'b0;
    ifc.req_we = 1'b0;
    ifc.req_addr = '0;
    ifc.req_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
`ifdef SRAM_CTRL_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
